fetch_unit: RTL

- Parametrised successor to the core's single-cycle PC / PC-adder / instruction-memory path.
- Decouples fetch from decode: issues sequential instruction requests to an instruction memory with a valid/ready request channel and an in-order response channel of arbitrary latency.
- Buffers returned instructions with their PC in a FIFO and presents them to decode via valid/ready.
- Supports redirect (branch/jump) with queue flush and discard of in-flight responses.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch.
// Issues sequential PC requests to an instruction memory and queues the
// returned words, each tagged with its PC, for the decode stage.
// A redirect flushes the queue and marks every outstanding response for
// discard, so stale instructions never reach decode.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// edge where valid and ready are both high. Valid never depends
// combinationally on ready. The memory response channel has no ready: one
// response arrives per accepted request, in request order.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_fetch,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_LIM = {1'b0, CW'(DEPTH)};

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   discard;
    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsbs;

    // Low address bits of the redirect target carry no meaning.
    assign target_pc            = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits already spent: queued entries plus responses still expected
    // that will be kept. Responses marked for discard cost no queue slot.
    assign occupancy = {1'b0, count} + {1'b0, inflight} - {1'b0, discard};

    // Request only when a queue slot is guaranteed for the answer. The
    // all-ones guard keeps the in-flight counter from wrapping if a slow
    // memory accumulates discarded responses across several redirects.
    assign imem_req_valid = !rst && !stall_fetch && !redirect &&
                            (occupancy < DEPTH_LIM) && (inflight != '1);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Head of queue; data and PC are don't-care while the queue is empty.
    assign instr_valid = !rst && (count != '0) && !redirect;
    assign instr_data  = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign pop         = instr_valid && instr_ready;

    // A response is kept only when no discard is pending and no redirect is
    // flushing the queue in the same cycle.
    assign push = imem_rsp_valid && !redirect && (discard == '0);

    // Control state: PCs, pointers and the three counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect) begin
            pc       <= target_pc;
            rsp_pc   <= target_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            // No request can fire here; everything still outstanding after
            // this cycle's response belongs to the old path.
            inflight <= inflight - CW'(imem_rsp_valid);
            discard  <= inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + XLEN'(4);
            end
            inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage: written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_data[wr_ptr] <= imem_rsp_data;
        end
    end

    // A response with nothing outstanding means the memory broke protocol.
    assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (inflight == '0)));

endmodule
